gpio_port: RTL and testbench
============================

GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 Parameter OUT_RESET, default 32'h0000_0000: reset value of the OUT register.
REQ-002 Parameter DIR_RESET, default 32'h0000_0000: reset value of the DIR register (1 = pin driven).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  CPU bus request present.
REQ-006 req_ready  output  1  block accepts request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  5  byte address; bits [4:2] select register, [1:0] ignored.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_wstrb  input  4  byte write enables; bit i covers wdata[8i+7:8i].
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  CPU accepts response.
REQ-013 resp_rdata  output  32  read data (0 for writes and errors).
REQ-014 resp_err  output  1  access to unmapped register.
REQ-015 gpio_in  input  32  asynchronous pin inputs.
REQ-016 gpio_out  output  32  OUT register value.
REQ-017 gpio_oe  output  32  DIR register value.
REQ-018 irq  output  1  level interrupt, registered.

Function
REQ-019 Register map SHALL be: 0x00 OUT RW; 0x04 DIR RW; 0x08 IN RO (writes ignored, no error); 0x0C IRQ_EN RW; 0x10 IRQ_STAT W1C; 0x14-0x1C unmapped.
REQ-020 The FSM SHALL have states IDLE and RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-021 On req_valid && req_ready in IDLE the block SHALL perform the access at that edge and enter RESP, so resp_valid rises one cycle after acceptance.
REQ-022 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_valid && resp_ready, then the FSM returns to IDLE; throughput is one transaction per two cycles at most.
REQ-023 Writes SHALL update only the bytes whose req_wstrb bit is set; wstrb = 0 writes nothing but still responds.
REQ-024 Unmapped accesses SHALL set resp_err = 1, resp_rdata = 0, and modify no state.
REQ-025 gpio_in SHALL pass through a 2-flop synchronizer; IN reads the second stage, so a pin change is visible to a read accepted 2 cycles later at the earliest.
REQ-026 A rising edge (third-stage 0, second-stage 1) on bit i SHALL set IRQ_STAT[i] when IRQ_EN[i] = 1.
REQ-027 A W1C write SHALL clear IRQ_STAT bits with 1 in enabled bytes; a set and a clear of the same bit at the same edge SHALL leave the bit set.
REQ-028 irq SHALL equal the registered value of |(IRQ_STAT & IRQ_EN), one cycle after either changes.
REQ-029 gpio_out and gpio_oe SHALL change at the accepting edge of a write, independent of response handshake.
REQ-030 req_valid while in RESP SHALL be ignored (not accepted, no state change).

Reset
REQ-031 When rst = 0 at a rising edge: FSM = IDLE, OUT = OUT_RESET, DIR = DIR_RESET, IRQ_EN = 0, IRQ_STAT = 0, synchronizer stages = 0, irq = 0, resp_rdata = 0, resp_err = 0.
REQ-032 Reset in RESP SHALL drop resp_valid at the next edge and discard the pending response.
REQ-033 Edges produced by synchronizer reset release SHALL NOT set IRQ_STAT for one cycle after reset deassertion.

Configuration
REQ-034 Macro GPIO_PORT_IRQ_EN defined: IRQ_EN, IRQ_STAT, edge detect and irq exist per REQ-026..028.
REQ-035 Macro GPIO_PORT_IRQ_EN undefined: 0x0C and 0x10 SHALL be unmapped (REQ-024), no interrupt flops exist, irq tied to 0.

Verification
REQ-036 Write 0x00 data 0xA5A5_1234 wstrb 4'b0011, then read 0x00 -> gpio_out = 0x0000_1234 after accept edge; read returns 0x0000_1234, resp_err = 0.
REQ-037 Read 0x14 -> resp_valid one cycle after accept, resp_rdata = 0, resp_err = 1; all registers unchanged.
REQ-038 Hold resp_ready = 0 for 5 cycles after a read of 0x04 -> resp_valid and resp_rdata stable 5 cycles, req_ready = 0, concurrent req_valid ignored.
REQ-039 IRQ_EN = 0x1, gpio_in[0] 0->1 -> IRQ_STAT[0] = 1 and irq = 1 within 4 cycles; W1C 0x1 to 0x10 -> irq = 0 one cycle later.
REQ-040 W1C of bit 0 at the same edge a new rising edge sets it -> IRQ_STAT[0] remains 1, irq stays 1.
REQ-041 Assert rst = 0 while resp_valid = 1 -> next edge resp_valid = 0, gpio_out = OUT_RESET, gpio_oe = DIR_RESET, irq = 0.

Source files
------------

// File: rtl/gpio_port.sv
// 32-bit GPIO port with a two-state request/response CPU bus slave.
// Optional interrupt logic (IRQ_EN, IRQ_STAT, edge detect, irq) is built when GPIO_PORT_IRQ_EN is defined.
module gpio_port #(
  parameter logic [31:0] OUT_RESET = 32'h0000_0000,
  parameter logic [31:0] DIR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_oe,
  output logic        irq
);

  localparam int DATA_W = 32;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t              state;
  logic [DATA_W-1:0]   out_reg;
  logic [DATA_W-1:0]   dir_reg;
  logic [DATA_W-1:0]   sync_p0;
  logic [DATA_W-1:0]   sync_p1;
  logic                accept;
  logic [2:0]          sel;
  logic                mapped;
  logic [DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]   wmask;
  logic                wr_out;
  logic                wr_dir;
  logic                unused_addr;

  function automatic logic [DATA_W-1:0] byte_mask(input logic [3:0] strb);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] wdata,
                                              input logic [DATA_W-1:0] mask);
    return (old & ~mask) | (wdata & mask);
  endfunction

  assign unused_addr = ^req_addr[1:0];
  assign gpio_out    = out_reg;
  assign gpio_oe     = dir_reg;

`ifdef GPIO_PORT_IRQ_EN
  logic [DATA_W-1:0] irq_en;
  logic [DATA_W-1:0] irq_stat;
  logic [DATA_W-1:0] sync_p2;
  logic [DATA_W-1:0] rise;
  logic              arm;
  logic              wr_en;
  logic              wr_clr;
`endif

  always_comb begin
    accept  = req_valid && req_ready;
    sel     = req_addr[4:2];
    wmask   = byte_mask(req_wstrb);
    mapped  = 1'b0;
    rd_data = '0;
    case (sel)
      3'd0: begin mapped = 1'b1; rd_data = out_reg; end
      3'd1: begin mapped = 1'b1; rd_data = dir_reg; end
      3'd2: begin mapped = 1'b1; rd_data = sync_p1; end
`ifdef GPIO_PORT_IRQ_EN
      3'd3: begin mapped = 1'b1; rd_data = irq_en; end
      3'd4: begin mapped = 1'b1; rd_data = irq_stat; end
`endif
      default: ;
    endcase
    wr_out = accept && req_we && (sel == 3'd0);
    wr_dir = accept && req_we && (sel == 3'd1);
`ifdef GPIO_PORT_IRQ_EN
    wr_en  = accept && req_we && (sel == 3'd3);
    wr_clr = accept && req_we && (sel == 3'd4);
`endif
  end

  // Bus FSM: the access happens at the accepting edge, the response is held until taken
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      out_reg    <= OUT_RESET;
      dir_reg    <= DIR_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= RESP;
            req_ready  <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= (req_we || !mapped) ? '0 : rd_data;
            resp_err   <= !mapped;
            if (wr_out) out_reg <= merge(out_reg, req_wdata, wmask);
            if (wr_dir) dir_reg <= merge(dir_reg, req_wdata, wmask);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Pin synchronizer: IN reads the second stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= gpio_in;
      sync_p1 <= sync_p0;
    end
  end

`ifdef GPIO_PORT_IRQ_EN
  assign rise = sync_p1 & ~sync_p2;

  // Edge detect and status: a set at the same edge as a W1C clear wins; arm masks the cycle after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p2  <= '0;
      arm      <= 1'b0;
      irq_en   <= '0;
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      sync_p2  <= sync_p1;
      arm      <= 1'b1;
      if (wr_en) irq_en <= merge(irq_en, req_wdata, wmask);
      irq_stat <= (irq_stat & ~(wr_clr ? (req_wdata & wmask) : '0))
                | (rise & irq_en & {DATA_W{arm}});
      irq      <= |(irq_stat & irq_en);
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_port.sv
// Scoreboard bench for gpio_port: stimulus pushes expected responses, a negedge monitor pops and compares.
// Interrupt checks are compiled in when GPIO_PORT_IRQ_EN is defined; otherwise 0x0C/0x10 must be unmapped.
module tb_gpio_port;

  localparam logic [31:0] OUT_RST = 32'h0000_0000;
  localparam logic [31:0] DIR_RST = 32'h0000_FF00;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  gpio_port #(.OUT_RESET(OUT_RST), .DIR_RESET(DIR_RST)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rdata %h err %b expected no response", resp_rdata, resp_err);
      end else begin
        mon_e = sb.pop_front();
        check32("resp_rdata", resp_rdata, mon_e.rdata);
        check32("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
      end
    end
  end

  // Caller sits just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb);
    logic ok;
    ok        = 1'b0;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ok = req_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    req_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready 0 for 20 cycles expected acceptance");
    end else begin
      check32("resp_latency", {31'b0, resp_valid}, 32'd1);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      if (!resp_valid) break;
      @(posedge clk); #1;
    end
    if (resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got resp_valid 1 after 20 cycles expected 0");
    end
  endtask

  task automatic access(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    send(we, addr, wdata, strb);
    wait_done();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    resp_ready = 1'b1;
    gpio_in    = '0;
    @(posedge clk); #1;
    cycles(2);

    // Reset state
    check32("rst_gpio_out", gpio_out, OUT_RST);
    check32("rst_gpio_oe", gpio_oe, DIR_RST);
    check32("rst_irq", {31'b0, irq}, 32'd0);
    check32("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check32("rst_req_ready", {31'b0, req_ready}, 32'd1);
    rst = 1'b1;
    cycles(2);

    // Byte-strobed write to OUT then read back
    access(1'b1, 5'h00, 32'hA5A5_1234, 4'b0011, 32'h0, 1'b0);
    check32("out_after_write", gpio_out, 32'h0000_1234);
    access(1'b0, 5'h00, 32'h0, 4'h0, 32'h0000_1234, 1'b0);

    // Upper-byte write to DIR keeps reset low bytes
    access(1'b1, 5'h04, 32'hFFFF_FFFF, 4'b1100, 32'h0, 1'b0);
    check32("dir_after_write", gpio_oe, 32'hFFFF_FF00);
    access(1'b0, 5'h04, 32'h0, 4'h0, 32'hFFFF_FF00, 1'b0);

    // wstrb = 0 writes nothing; low address bits ignored
    access(1'b1, 5'h00, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    access(1'b0, 5'h03, 32'h0, 4'h0, 32'h0000_1234, 1'b0);

    // Unmapped accesses
    access(1'b0, 5'h14, 32'h0, 4'h0, 32'h0, 1'b1);
    access(1'b1, 5'h18, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);
    check32("out_after_unmapped", gpio_out, 32'h0000_1234);
    check32("dir_after_unmapped", gpio_oe, 32'hFFFF_FF00);

    // IN through the synchronizer: a read accepted one edge after the change still sees the old value
    gpio_in = 32'h5A5A_0F0F;
    access(1'b0, 5'h08, 32'h0, 4'h0, 32'h0, 1'b0);
    access(1'b0, 5'h08, 32'h0, 4'h0, 32'h5A5A_0F0F, 1'b0);
    access(1'b1, 5'h08, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);

    // Response held under backpressure; concurrent request ignored
    resp_ready = 1'b0;
    sb.push_back('{rdata: 32'hFFFF_FF00, err: 1'b0});
    send(1'b0, 5'h04, 32'h0, 4'h0);
    req_we    = 1'b1;
    req_addr  = 5'h00;
    req_wdata = 32'hFFFF_FFFF;
    req_wstrb = 4'hF;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check32("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      check32("hold_resp_rdata", resp_rdata, 32'hFFFF_FF00);
      check32("hold_req_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    wait_done();
    check32("out_after_ignored_req", gpio_out, 32'h0000_1234);

`ifdef GPIO_PORT_IRQ_EN
    // Rising edge on an enabled bit raises irq; W1C clears it
    gpio_in = 32'h0;
    cycles(4);
    access(1'b1, 5'h0C, 32'h0000_0001, 4'b0001, 32'h0, 1'b0);
    access(1'b0, 5'h0C, 32'h0, 4'h0, 32'h0000_0001, 1'b0);
    check32("irq_before_edge", {31'b0, irq}, 32'd0);
    gpio_in = 32'h0000_0001;
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (irq) begin n = i; break; end
    end
    check32("irq_rise_cycles", {31'b0, (n >= 1 && n <= 4)}, 32'd1);
    access(1'b0, 5'h10, 32'h0, 4'h0, 32'h0000_0001, 1'b0);
    access(1'b1, 5'h10, 32'h0000_0001, 4'b0000, 32'h0, 1'b0);
    access(1'b0, 5'h10, 32'h0, 4'h0, 32'h0000_0001, 1'b0);
    check32("irq_after_nostrb_w1c", {31'b0, irq}, 32'd1);
    access(1'b1, 5'h10, 32'h0000_0001, 4'b0001, 32'h0, 1'b0);
    check32("irq_after_w1c", {31'b0, irq}, 32'd0);
    access(1'b0, 5'h10, 32'h0, 4'h0, 32'h0, 1'b0);

    // W1C at the same edge as a new rising edge: set wins
    gpio_in = 32'h0;
    cycles(4);
    gpio_in = 32'h0000_0001;
    cycles(2);
    access(1'b1, 5'h10, 32'h0000_0001, 4'b0001, 32'h0, 1'b0);
    access(1'b0, 5'h10, 32'h0, 4'h0, 32'h0000_0001, 1'b0);
    check32("irq_set_wins", {31'b0, irq}, 32'd1);
`else
    // Interrupt registers absent: unmapped and irq tied low
    access(1'b0, 5'h0C, 32'h0, 4'h0, 32'h0, 1'b1);
    access(1'b1, 5'h10, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    gpio_in = 32'h0;
    cycles(3);
    gpio_in = 32'hFFFF_FFFF;
    cycles(4);
    check32("irq_tied_low", {31'b0, irq}, 32'd0);
`endif

    // Reset while a response is pending discards it
    resp_ready = 1'b0;
    send(1'b0, 5'h04, 32'h0, 4'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check32("rst_resp_valid_drop", {31'b0, resp_valid}, 32'd0);
    check32("rst_resp_gpio_out", gpio_out, OUT_RST);
    check32("rst_resp_gpio_oe", gpio_oe, DIR_RST);
    check32("rst_resp_irq", {31'b0, irq}, 32'd0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check32("rst_resp_req_ready", {31'b0, req_ready}, 32'd1);
    rst        = 1'b1;
    resp_ready = 1'b1;
    cycles(3);
    check32("no_resp_after_rst", {31'b0, resp_valid}, 32'd0);
    check32("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
